// File: rtl/od_line_arbiter_if.sv
// Bundle between the open-drain line arbiter and its requesters / line buffer stage.
// Carries level requests, line readback, one-hot grant, open-drain drive and status.
// master = arbiter side (drives grant/drive/status); slave = requester/line side.
interface od_line_arbiter_if #(
    parameter int N_REQ = 6
);
    localparam int IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [N_REQ-1:0] req;       // level request per requester
    logic             line_in;   // wired-line readback: 1 = released, 0 = pulled low
    logic [N_REQ-1:0] gnt;       // one-hot grant, held for the whole transaction
    logic [N_REQ-1:0] drv_a;     // open-drain inverter inputs: 1 pulls the line low
    logic             busy;      // high outside IDLE
    logic             done;      // one-cycle pulse at the end of a transaction
    logic             fault;     // sticky readback fault
    logic [IDW-1:0]   fault_id;  // requester granted when the fault was seen

    modport master (
        input  req, line_in,
        output gnt, drv_a, busy, done, fault, fault_id
    );

    modport slave (
        output req, line_in,
        input  gnt, drv_a, busy, done, fault, fault_id
    );
endinterface

// File: rtl/od_line_arbiter.sv
// Round-robin arbiter that shares one open-drain wired line between N_REQ requesters.
// Latency: grant/drive one cycle after a request is seen in IDLE; transaction = PULSE+RELEASE+1 cycles.
// Backpressure: none; requests are levels, held off while busy, and never abort a running transaction.
//
// Ports: clk, rst (synchronous, active-low), bus (od_line_arbiter_if.master).
// Optional: define OD_ARB_READBACK_EN to enable line readback checks and the absorbing FAULT state;
// without it line_in is ignored and fault/fault_id are tied low.
module od_line_arbiter #(
    parameter int N_REQ          = 6,
    parameter int PULSE_CYCLES   = 4,
    parameter int RELEASE_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    od_line_arbiter_if.master bus
);
    localparam int IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRIVE,
        S_RELEASE,
`ifdef OD_ARB_READBACK_EN
        S_FAULT,
`endif
        S_DONE
    } state_t;

    state_t           state;
    logic [7:0]       cnt;
    logic [IDW-1:0]   last;      // last requester served; search starts one above it
    logic [IDW-1:0]   idx;       // requester owning the current transaction
    logic [N_REQ-1:0] gnt_q;
    logic [N_REQ-1:0] drv_q;
    logic             busy_q;
    logic             done_q;

    // Round-robin pick: first set request searching upward from last+1, wrapping.
    logic             sel_found;
    logic [IDW-1:0]   sel_idx;
    logic [IDW-1:0]   cand_idx;
    logic [N_REQ-1:0] sel_onehot;
    int               cand;

    always_comb begin
        sel_found  = 1'b0;
        sel_idx    = '0;
        cand       = 0;
        cand_idx   = '0;
        for (int off = 1; off <= N_REQ; off++) begin
            cand     = (int'(last) + off) % N_REQ;
            cand_idx = IDW'(cand);
            if (!sel_found && bus.req[cand_idx]) begin
                sel_found = 1'b1;
                sel_idx   = cand_idx;
            end
        end
        sel_onehot          = '0;
        sel_onehot[sel_idx] = 1'b1;
    end

`ifdef OD_ARB_READBACK_EN
    logic           fault_q;
    logic [IDW-1:0] fault_id_q;
`else
    logic unused_line_in;
    assign unused_line_in = bus.line_in;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= S_IDLE;
            cnt    <= '0;
            last   <= IDW'(N_REQ - 1);
            idx    <= '0;
            gnt_q  <= '0;
            drv_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
`ifdef OD_ARB_READBACK_EN
            fault_q    <= 1'b0;
            fault_id_q <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (sel_found) begin
                        idx    <= sel_idx;
                        gnt_q  <= sel_onehot;
                        drv_q  <= sel_onehot;
                        busy_q <= 1'b1;
                        cnt    <= 8'(PULSE_CYCLES - 1);
                        state  <= S_DRIVE;
                    end
                end
                S_DRIVE: begin
                    if (cnt == '0) begin
                        drv_q <= '0;
                        cnt   <= 8'(RELEASE_CYCLES - 1);
                        state <= S_RELEASE;
`ifdef OD_ARB_READBACK_EN
                        // Line should still be pulled low on the last drive cycle.
                        if (bus.line_in) begin
                            gnt_q      <= '0;
                            fault_q    <= 1'b1;
                            fault_id_q <= idx;
                            state      <= S_FAULT;
                        end
`endif
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                S_RELEASE: begin
                    if (cnt == '0) begin
                        gnt_q  <= '0;
                        done_q <= 1'b1;
                        last   <= idx;
                        state  <= S_DONE;
`ifdef OD_ARB_READBACK_EN
                        // Pull-up must have restored the line by the end of release.
                        if (!bus.line_in) begin
                            done_q     <= 1'b0;
                            last       <= last;
                            fault_q    <= 1'b1;
                            fault_id_q <= idx;
                            state      <= S_FAULT;
                        end
`endif
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                S_DONE: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    state  <= S_IDLE;
                end
`ifdef OD_ARB_READBACK_EN
                S_FAULT: begin
                    // Absorbing until reset: no grants, line released, busy held.
                    gnt_q  <= '0;
                    drv_q  <= '0;
                    busy_q <= 1'b1;
                end
`endif
                default: begin
                    gnt_q  <= '0;
                    drv_q  <= '0;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                    state  <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.gnt   = gnt_q;
    assign bus.drv_a = drv_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
`ifdef OD_ARB_READBACK_EN
    assign bus.fault    = fault_q;
    assign bus.fault_id = fault_id_q;
`else
    assign bus.fault    = 1'b0;
    assign bus.fault_id = '0;
`endif
endmodule

// File: tb/tb_od_line_arbiter.sv
// Self-checking bench for od_line_arbiter (N_REQ=6, PULSE=4, RELEASE=2).
// Line model: pull-up AND NOT(|drv_a), with bench overrides to force stuck-low / stuck-high.
// Fault scenarios expect a fault when OD_ARB_READBACK_EN is defined, a normal transaction otherwise.
module tb_od_line_arbiter;
    localparam int N = 6;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [N-1:0] req_r = '0;
    logic force_lo = 1'b0;
    logic force_hi = 1'b0;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    od_line_arbiter_if #(.N_REQ(N)) bus_if ();

    assign bus_if.req     = req_r;
    assign bus_if.line_in = force_lo ? 1'b0 : (force_hi ? 1'b1 : ~(|bus_if.drv_a));

    od_line_arbiter #(
        .N_REQ(N),
        .PULSE_CYCLES(4),
        .RELEASE_CYCLES(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus_if)
    );

    typedef struct packed {
        logic         rst;
        logic [N-1:0] req;
        logic [N-1:0] gnt;
        logic [N-1:0] drv;
        logic         busy;
        logic         done;
    } vec_t;

    vec_t tbl [17];

    function automatic vec_t v(logic r, logic [N-1:0] q, logic [N-1:0] g, logic [N-1:0] d,
                               logic b, logic dn);
        vec_t x;
        x.rst = r; x.req = q; x.gnt = g; x.drv = d; x.busy = b; x.done = dn;
        return x;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst   = 1'b0;
        req_r = '0;
        step();
        rst   = 1'b1;
    endtask

    // Steps until a grant appears (bounded), checking one-hot on the way.
    task automatic wait_gnt();
        for (int i = 0; i < 20; i++) begin
            step();
            chk("onehot_gnt", 32'($onehot0(bus_if.gnt)), 32'd1);
            chk("onehot_drv", 32'($onehot0(bus_if.drv_a)), 32'd1);
            if (bus_if.gnt != '0) break;
        end
    endtask

    task automatic wait_done();
        for (int i = 0; i < 20; i++) begin
            step();
            if (bus_if.done) break;
        end
        chk("done_seen", 32'(bus_if.done), 32'd1);
    endtask

    int exp_order [6] = '{0, 3, 5, 0, 3, 5};
    int drv_cnt;
    int rel_cnt;
    int bad_gnt;

    initial begin
        // Reset, then a single persistent requester: two back-to-back transactions.
        tbl[0]  = v(1'b0, 6'b000000, 6'b000000, 6'b000000, 1'b0, 1'b0);
        tbl[1]  = v(1'b1, 6'b000001, 6'b000001, 6'b000001, 1'b1, 1'b0);
        tbl[2]  = v(1'b1, 6'b000001, 6'b000001, 6'b000001, 1'b1, 1'b0);
        tbl[3]  = v(1'b1, 6'b000001, 6'b000001, 6'b000001, 1'b1, 1'b0);
        tbl[4]  = v(1'b1, 6'b000001, 6'b000001, 6'b000001, 1'b1, 1'b0);
        tbl[5]  = v(1'b1, 6'b000001, 6'b000001, 6'b000000, 1'b1, 1'b0);
        tbl[6]  = v(1'b1, 6'b000001, 6'b000001, 6'b000000, 1'b1, 1'b0);
        tbl[7]  = v(1'b1, 6'b000001, 6'b000000, 6'b000000, 1'b1, 1'b1);
        tbl[8]  = v(1'b1, 6'b000001, 6'b000000, 6'b000000, 1'b0, 1'b0);
        tbl[9]  = v(1'b1, 6'b000001, 6'b000001, 6'b000001, 1'b1, 1'b0);
        tbl[10] = v(1'b1, 6'b000001, 6'b000001, 6'b000001, 1'b1, 1'b0);
        tbl[11] = v(1'b1, 6'b000001, 6'b000001, 6'b000001, 1'b1, 1'b0);
        tbl[12] = v(1'b1, 6'b000001, 6'b000001, 6'b000001, 1'b1, 1'b0);
        tbl[13] = v(1'b1, 6'b000001, 6'b000001, 6'b000000, 1'b1, 1'b0);
        tbl[14] = v(1'b1, 6'b000001, 6'b000001, 6'b000000, 1'b1, 1'b0);
        tbl[15] = v(1'b1, 6'b000001, 6'b000000, 6'b000000, 1'b1, 1'b1);
        tbl[16] = v(1'b1, 6'b000001, 6'b000000, 6'b000000, 1'b0, 1'b0);

        #2;
        for (int r = 0; r < 17; r++) begin
            rst   = tbl[r].rst;
            req_r = tbl[r].req;
            step();
            chk($sformatf("tbl%0d_gnt", r),  32'(bus_if.gnt),   32'(tbl[r].gnt));
            chk($sformatf("tbl%0d_drv", r),  32'(bus_if.drv_a), 32'(tbl[r].drv));
            chk($sformatf("tbl%0d_busy", r), 32'(bus_if.busy),  32'(tbl[r].busy));
            chk($sformatf("tbl%0d_done", r), 32'(bus_if.done),  32'(tbl[r].done));
        end
        chk("tbl_fault", 32'(bus_if.fault), 32'd0);
        chk("tbl_fault_id", 32'(bus_if.fault_id), 32'd0);

        // Round-robin order with three requesters held.
        do_reset();
        req_r = 6'b101001;
        for (int g = 0; g < 6; g++) begin
            wait_gnt();
            chk($sformatf("rr_gnt%0d", g), 32'(bus_if.gnt), 32'(1) << exp_order[g]);
            wait_done();
        end

        // Request dropped mid-DRIVE: pulse still completes.
        do_reset();
        req_r = 6'b000100;
        wait_gnt();
        chk("drop_gnt", 32'(bus_if.gnt), 32'h04);
        drv_cnt = bus_if.drv_a[2] ? 1 : 0;
        rel_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (i == 0) req_r = '0;
            if (bus_if.done) break;
            if (bus_if.drv_a[2]) drv_cnt++;
            else if (bus_if.gnt[2]) rel_cnt++;
        end
        chk("drop_done", 32'(bus_if.done), 32'd1);
        chk("drop_drv_cycles", 32'(drv_cnt), 32'd4);
        chk("drop_rel_cycles", 32'(rel_cnt), 32'd2);
        step();
        step();
        chk("drop_no_regrant", 32'(bus_if.gnt), 32'd0);

        // Line held low during RELEASE for requester 4.
        do_reset();
        req_r = 6'b010000;
        wait_gnt();
        chk("slow_gnt", 32'(bus_if.gnt), 32'h10);
        for (int i = 0; i < 10; i++) begin
            if (bus_if.gnt != '0 && bus_if.drv_a == '0) break;
            step();
        end
        force_lo = 1'b1;
        step();
        step();
        force_lo = 1'b0;
`ifdef OD_ARB_READBACK_EN
        chk("slow_fault", 32'(bus_if.fault), 32'd1);
        chk("slow_fault_id", 32'(bus_if.fault_id), 32'd4);
        chk("slow_drv", 32'(bus_if.drv_a), 32'd0);
        chk("slow_gnt_off", 32'(bus_if.gnt), 32'd0);
        chk("slow_busy", 32'(bus_if.busy), 32'd1);
        req_r   = 6'b111111;
        bad_gnt = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (bus_if.gnt != '0 || bus_if.drv_a != '0) bad_gnt++;
        end
        chk("fault_absorbing", 32'(bad_gnt), 32'd0);
        chk("fault_sticky", 32'(bus_if.fault), 32'd1);
        rst = 1'b0;
        step();
        rst = 1'b1;
        chk("fault_cleared", 32'(bus_if.fault), 32'd0);
        chk("fault_id_cleared", 32'(bus_if.fault_id), 32'd0);
        chk("fault_busy_cleared", 32'(bus_if.busy), 32'd0);
`else
        chk("slow_done", 32'(bus_if.done), 32'd1);
        chk("slow_no_fault", 32'(bus_if.fault), 32'd0);
`endif

        // Line stuck high throughout DRIVE.
        do_reset();
        force_hi = 1'b1;
        req_r    = 6'b000001;
        wait_gnt();
        chk("high_gnt", 32'(bus_if.gnt), 32'h01);
        step();
        step();
        step();
        chk("high_pre_fault", 32'(bus_if.fault), 32'd0);
        step();
`ifdef OD_ARB_READBACK_EN
        chk("high_fault", 32'(bus_if.fault), 32'd1);
        chk("high_fault_id", 32'(bus_if.fault_id), 32'd0);
        chk("high_drv", 32'(bus_if.drv_a), 32'd0);
        chk("high_gnt_off", 32'(bus_if.gnt), 32'd0);
`else
        chk("high_release_gnt", 32'(bus_if.gnt), 32'h01);
        step();
        step();
        chk("high_done", 32'(bus_if.done), 32'd1);
        chk("high_no_fault", 32'(bus_if.fault), 32'd0);
`endif
        force_hi = 1'b0;

        // Reset on the third DRIVE cycle; pointer returns to requester 0.
        do_reset();
        req_r = 6'b000001;
        wait_gnt();
        wait_done();
        req_r = 6'b000010;
        wait_gnt();
        chk("rst_gnt1", 32'(bus_if.gnt), 32'h02);
        step();
        step();
        rst = 1'b0;
        step();
        chk("rst_drv", 32'(bus_if.drv_a), 32'd0);
        chk("rst_gnt", 32'(bus_if.gnt), 32'd0);
        chk("rst_busy", 32'(bus_if.busy), 32'd0);
        rst   = 1'b1;
        req_r = 6'b000011;
        step();
        chk("rst_first_gnt", 32'(bus_if.gnt), 32'h01);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
